// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_read_arbiter : round-robin burst arbiter for a shared FIFO read port
// Revision 1.0
// ============================================================================
module fifo_read_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int BURST_WIDTH = 4,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BURST_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_rdata,
  output logic                           fifo_rinc,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic [ID_WIDTH-1:0]            out_id,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic                           burst_abort
);

  localparam logic [BURST_WIDTH:0] ONE     = 1;
  localparam logic [NUM_REQ-1:0]   GNT_ONE = 1;
  localparam logic [ID_WIDTH-1:0]  LAST_RST = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ID_WIDTH-1:0]    last_id;
  logic [ID_WIDTH-1:0]    winner;
  logic [ID_WIDTH-1:0]    cand;
  logic                   found;
  logic [BURST_WIDTH:0]   remaining;
  logic [BURST_WIDTH-1:0] win_len;
  logic                   abort;
  logic                   done;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_id) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_len = req_len[int'(winner)*BURST_WIDTH +: BURST_WIDTH];

  always_comb begin
    state_next = state;
    fifo_rinc  = 1'b0;
    abort      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_next = BURST;
      end
      BURST: begin
        if (!req[last_id]) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (!fifo_empty && (!out_valid || out_ready)) begin
          fifo_rinc = 1'b1;
          if (remaining == ONE) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      last_id     <= LAST_RST;
      remaining   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_last    <= 1'b0;
      burst_abort <= 1'b0;
    end else begin
      burst_abort <= abort;
      if (state == IDLE && found) begin
        gnt       <= GNT_ONE << winner;
        last_id   <= winner;
        remaining <= {1'b0, win_len} + ONE;
      end else if (abort || done) begin
        gnt <= '0;
      end
      // A pop refills the output register even while the old word is being taken.
      if (fifo_rinc) begin
        remaining <= remaining - ONE;
        out_data  <= fifo_rdata;
        out_id    <= last_id;
        out_valid <= 1'b1;
        out_last  <= (remaining == ONE);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_read_arbiter : directed scoreboard bench for fifo_read_arbiter
// Revision 1.0
// ============================================================================
module tb_fifo_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  gnt;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_rinc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_id;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        burst_abort;

  int total = 0;
  int bad   = 0;

  fifo_read_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .BURST_WIDTH(4),
    .ID_WIDTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rinc  (fifo_rinc),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  // FIFO model: bench writes, DUT pops.
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush  = 1'b0;
  always @(posedge clk) begin
    if (flush)          rd_ptr <= wr_ptr;
    else if (fifo_rinc) rd_ptr <= rd_ptr + 1;
  end
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr[5:0]];

  typedef struct {
    logic [7:0] d;
    logic [1:0] id;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_word: got data=%0h id=%0d last=%0b want nothing", out_data, out_id, out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.d || out_id !== e.id || out_last !== e.last) begin
          bad++;
          $display("FAIL sb_word: got data=%0h id=%0d last=%0b want data=%0h id=%0d last=%0b",
                   out_data, out_id, out_last, e.d, e.id, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[wr_ptr[5:0]] = base + 8'(k);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic [1:0] id, input logic last);
    exp_t e;
    e.d = d; e.id = id; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && gnt != 4'b0000; i++) tick();
    check(name, gnt, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    rst = 1'b1;
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_id", out_id, 0);
    check("rst_last", out_last, 0);
    check("rst_abort", burst_abort, 0);
    check("rst_rinc", fifo_rinc, 0);
    rst = 1'b0;

    // Single burst of 4 from requester 0
    load(10, 8'hA0);
    for (int k = 0; k < 4; k++) expect_word(8'hA0 + 8'(k), 2'd0, k == 3);
    req = 4'b0001; req_len[3:0] = 4'd3;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      check("t1_rinc", fifo_rinc, 1);
      check("t1_gnt_hold", gnt, 4'b0001);
      tick();
    end
    req = 4'b0000;
    check("t1_gnt_end", gnt, 0);
    check("t1_last", out_last, 1);
    check("t1_left", wr_ptr - rd_ptr, 6);
    tick();

    // Round robin 0,1,2,3,0 with one idle cycle between grants
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    load(5, 8'hB0);
    for (int g = 0; g < 5; g++) expect_word(8'hB0 + 8'(g), 2'(g % 4), 1'b1);
    req_len = '0; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("t2_gnt", gnt, 32'(4'b0001 << (g % 4)));
      check("t2_rinc", fifo_rinc, 1);
      tick();
      check("t2_idle", gnt, 0);
      if (g == 4) req = 4'b0000;
    end
    tick();

    // Backpressure: requester 1, 8 words, out_ready low for 3 cycles
    do_flush();
    load(8, 8'hC0);
    for (int k = 0; k < 8; k++) expect_word(8'hC0 + 8'(k), 2'd1, k == 7);
    req = 4'b0010; req_len[7:4] = 4'd7;
    tick();
    check("t3_gnt", gnt, 4'b0010);
    tick(); tick();
    out_ready = 1'b0;
    #1;
    check("t3_rinc_stall", fifo_rinc, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_data", out_data, 8'hC1);
      check("t3_hold_valid", out_valid, 1);
      check("t3_rinc", fifo_rinc, 0);
    end
    out_ready = 1'b1;
    wait_idle("t3_done");
    req = 4'b0000;
    check("t3_drained", wr_ptr - rd_ptr, 0);
    tick();

    // Empty stall: requester 2, 5 words, only 2 available at first
    do_flush();
    load(2, 8'hD0);
    for (int k = 0; k < 5; k++) expect_word(8'hD0 + 8'(k), 2'd2, k == 4);
    req = 4'b0100; req_len[11:8] = 4'd4;
    tick();
    check("t4_gnt", gnt, 4'b0100);
    tick(); tick();
    check("t4_rinc_empty", fifo_rinc, 0);
    tick(); tick(); tick();
    check("t4_gnt_held", gnt, 4'b0100);
    check("t4_rinc_still", fifo_rinc, 0);
    load(3, 8'hD2);
    wait_idle("t4_done");
    req = 4'b0000;
    check("t4_last", out_last, 1);
    check("t4_last_data", out_data, 8'hD4);
    tick();

    // Abort: requester 2 drops after 2 of 6 words, requester 3 takes over
    do_flush();
    load(10, 8'hE0);
    expect_word(8'hE0, 2'd2, 1'b0);
    expect_word(8'hE1, 2'd2, 1'b0);
    expect_word(8'hE2, 2'd3, 1'b1);
    req = 4'b0100; req_len[11:8] = 4'd5; req_len[15:12] = 4'd0;
    tick();
    check("t5_gnt", gnt, 4'b0100);
    tick(); tick();
    req = 4'b1000;
    #1;
    check("t5_rinc_drop", fifo_rinc, 0);
    tick();
    check("t5_abort", burst_abort, 1);
    check("t5_gnt_off", gnt, 0);
    check("t5_rinc_idle", fifo_rinc, 0);
    tick();
    check("t5_abort_pulse", burst_abort, 0);
    check("t5_next_gnt", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    check("t5_popped", wr_ptr - rd_ptr, 7);
    tick();

    // Reset mid-burst
    do_flush();
    load(10, 8'hF0);
    expect_word(8'hF0, 2'd1, 1'b0);
    req = 4'b0010; req_len[7:4] = 4'd7;
    tick();
    check("t6_gnt", gnt, 4'b0010);
    tick(); tick();
    rst = 1'b1; out_ready = 1'b0; req = 4'b0011;
    tick();
    check("t6_gnt_rst", gnt, 0);
    check("t6_valid_rst", out_valid, 0);
    check("t6_data_rst", out_data, 0);
    check("t6_id_rst", out_id, 0);
    check("t6_last_rst", out_last, 0);
    check("t6_abort_rst", burst_abort, 0);
    check("t6_rinc_rst", fifo_rinc, 0);
    rst = 1'b0; out_ready = 1'b1; req_len[3:0] = 4'd0;
    expect_word(8'hF2, 2'd0, 1'b1);
    tick();
    check("t6_gnt0", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    check("t6_gnt_end", gnt, 0);
    tick(); tick(); tick();

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
